// File: rtl/data_mem_hs_if.sv
// data_mem_hs_if: request/response bundle for data_mem_hs.
// master = LSU side (drives req_*, rsp_ready), slave = memory side.
interface data_mem_hs_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, err_cnt
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, err_cnt
  );
endinterface

// File: rtl/data_mem_hs.sv
// data_mem_hs: byte-addressable data memory, valid/ready req/rsp,
// sub-word loads/stores, alignment/range error response, sat. err count.
// Ports: clk, rst (async high), bus (data_mem_hs_if.slave).
module data_mem_hs #(
  parameter int DEPTH_WORDS = 32,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  data_mem_hs_if.slave bus
);
  localparam int BYTE_W = $clog2(4 * DEPTH_WORDS);
  localparam int IDX_W  = BYTE_W - 2;

  logic             r_valid;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;

  logic             w_acc;
  logic             w_oor;
  logic             w_misal;
  logic             w_err;
  logic             w_wr;
  logic [1:0]       w_lane;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wlane;
  logic [31:0]      w_rword;
  logic [7:0]       w_b;
  logic [15:0]      w_h;
  logic [31:0]      w_ld;

  // One-entry response slot; a drain and a new accept may share an edge.
  assign bus.req_ready = !r_valid || bus.rsp_ready;
  assign w_acc  = bus.req_valid && bus.req_ready;
  assign w_lane = bus.req_addr[1:0];
  assign w_idx  = bus.req_addr[BYTE_W-1:2];

  if (ADDR_W > BYTE_W) begin : g_hi
    assign w_oor = |bus.req_addr[ADDR_W-1:BYTE_W];
  end else begin : g_nohi
    assign w_oor = 1'b0;
  end

  always_comb begin
    w_misal = 1'b0;
    case (bus.req_size)
      2'b01:   w_misal = w_lane[0];
      2'b10:   w_misal = |w_lane;
      default: w_misal = 1'b0;
    endcase
  end

  assign w_err = (bus.req_size == 2'b11) || w_misal || w_oor;

  // Store data is replicated across lanes; byte enables pick the lanes.
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wlane = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wlane = bus.req_wdata;
      end
      default: begin
        w_be    = 4'b0000;
        w_wlane = bus.req_wdata;
      end
    endcase
  end

  // Reset gates the write so an edge during rst never commits.
  assign w_wr = w_acc && !w_err && bus.req_we && !rst;

  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [7:0] r_bank [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (w_wr && w_be[g])
        r_bank[w_idx] <= w_wlane[g*8 +: 8];
    end

    assign w_rword[g*8 +: 8] = r_bank[w_idx];
  end

  assign w_b = w_rword[{w_lane, 3'b000} +: 8];
  assign w_h = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_ld = w_rword;
    case (bus.req_size)
      2'b00:   w_ld = {{24{bus.req_signed & w_b[7]}}, w_b};
      2'b01:   w_ld = {{16{bus.req_signed & w_h[15]}}, w_h};
      default: w_ld = w_rword;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_err   <= w_err;
      r_rdata <= (w_err || bus.req_we) ? '0 : w_ld;
      if (w_err && !(&r_cnt))
        r_cnt <= r_cnt + CNT_W'(1);
    end else if (bus.rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_valid;
  assign bus.rsp_err   = r_err;
  assign bus.rsp_rdata = r_rdata;
  assign bus.err_cnt   = r_cnt;
endmodule

// File: doc/data_mem_hs.md
# data_mem_hs

Parametrised, byte-addressable data memory with a valid/ready request/response handshake. It serves the CPU's load/store path and supports byte, half and word stores and signed or unsigned sub-word loads. It adds output back-pressure, alignment and range checking with an error response, and a saturating error counter. It sits between the LSU and the memory stage's write-back mux.

## Interface
Parameters:
- `DEPTH_WORDS`, default 32: memory size in 32-bit words (byte capacity = 4*DEPTH_WORDS); must be a power of two ≥ 2.
- `ADDR_W`, default 32: request address width in bytes.
- `CNT_W`, default 16: error counter width.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved (error).
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, little-endian, low bytes used for sub-word.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned, out of range or reserved size.
- `err_cnt`  out  CNT_W  saturating count of error responses.

## Operation
- Storage: four byte-lane banks of DEPTH_WORDS entries each, word index = `req_addr[log2(4*DEPTH_WORDS)-1:2]`, lane = `req_addr[1:0]`. Memory contents are not reset and are retained across `rst`.
- Accept: a request is accepted on a rising edge where `req_valid && req_ready`. `req_ready = !rsp_valid || rsp_ready` (one-entry response register, pass-through when drained).
- Error check at accept: the error flag is set if any of the following holds:
  - `req_size == 11`;
  - half with `req_addr[0] != 0`;
  - word with `req_addr[1:0] != 0`;
  - `req_addr ≥ 4*DEPTH_WORDS` (upper address bits nonzero).
  Errored requests write nothing. Their response is `rsp_err = 1`, `rsp_rdata = 0`.
- Store: written byte lanes are committed at the accept edge.
  - Byte writes the lane at `addr[1:0]`.
  - Half writes lanes `addr[1]*2` and `+1`.
  - Word writes all four lanes.
  - Other lanes are untouched. The response has `rsp_err = 0` and `rsp_rdata = 0`.
- Load: the aligned word is read at the accept edge, then lane-selected and extended into `rsp_rdata`.
  - Byte: bits [7:0] from the addressed lane.
  - Half: bits [15:0] from lanes {`addr[1]*2+1`, `addr[1]*2`}.
  - Extension: sign bit 7/15 replicated if `req_signed`, else zeros. `req_signed` is ignored for word loads.
- `err_cnt` increments by 1 at each accept edge of an errored request and saturates at all-ones.

## Timing
- Reset (async, immediate): `rsp_valid = 0`, `rsp_err = 0`, `rsp_rdata = 0`, `err_cnt = 0`; `req_ready` becomes 1. A response pending at reset is dropped. No write occurs on any edge while `rst = 1`.
- Latency: the response is valid exactly 1 cycle after the accept edge. Throughput is 1 request/cycle while `rsp_ready = 1`.
- Back-pressure: while `rsp_valid && !rsp_ready`, `rsp_valid`, `rsp_rdata` and `rsp_err` hold stable and `req_ready = 0`. No request is accepted and no store is committed.
- Response drain: the response is consumed on an edge with `rsp_valid && rsp_ready`. If a new request is accepted on the same edge, its response replaces it with no bubble. Otherwise `rsp_valid` falls to 0.
- Ordering: store then load to the same address on consecutive accepts returns the new data. The store commits at edge N and the load samples the array at edge N+1, so no forwarding path is required.
- Inputs are sampled only at the accept edge; changes on `req_*` while not accepted have no effect.

## Test plan
- Word round trip: store word 0x12345678 @0x10, then load word @0x10 → `rsp_rdata = 0x12345678`, `rsp_err = 0`, each response 1 cycle after accept. A byte-unsigned load @0x13 → 0x00000012.
- Sub-word extension: store byte 0x80 @0x21, then load byte signed @0x21 → 0xFFFFFF80 and unsigned → 0x00000080. Store half 0x8001 @0x22, then load half signed → 0xFFFF8001, and load word @0x20 → 0x800180xx with byte 0x20 unchanged.
- Errors: load half @0x03, store word @0x06 and load byte @4*DEPTH_WORDS → all give `rsp_err = 1`, `rsp_rdata = 0`, `err_cnt = 3`. A subsequent load of word @0x04 shows the errored store did not write.
- Back-pressure: issue 3 back-to-back loads with `rsp_ready = 0` for 4 cycles → `req_ready = 0` after the first accept and the first response held stable. After `rsp_ready = 1`, the 3 responses arrive in order on consecutive cycles.
- Reset mid-operation: assert `rst` asynchronously while a response is pending and a store is presented → outputs clear immediately, the store is not committed, and memory written before reset still reads back correctly after release.
- Counter saturation: with `CNT_W = 2`, issue 5 errored requests → `err_cnt` reads 1, 2, 3, 3, 3.
